// File: rtl/egress_drain_arbiter.sv
// Egress reader for the 4x4 fabric: round-robin drain of fifo4..fifo7 into one
// registered ready/valid stream, with per-port delivery counts and tag checking.
module egress_drain_arbiter #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fifo4_out,
    input  logic [WIDTH-1:0] fifo5_out,
    input  logic [WIDTH-1:0] fifo6_out,
    input  logic [WIDTH-1:0] fifo7_out,
    input  logic             fifo4_empty,
    input  logic             fifo5_empty,
    input  logic             fifo6_empty,
    input  logic             fifo7_empty,
    output logic             pop4,
    output logic             pop5,
    output logic             pop6,
    output logic             pop7,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [1:0]       src_out,
    output logic             tag_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cnt4,
    output logic [CNT_W-1:0] cnt5,
    output logic [CNT_W-1:0] cnt6,
    output logic [CNT_W-1:0] cnt7
);

    logic [WIDTH-1:0] head [4];
    logic [3:0]       avail;
    logic [1:0]       rr;
    logic [1:0]       grant_idx;
    logic [1:0]       scan_idx;
    logic             grant_vld;
    logic             can_load;
    logic             do_pop;
    logic [WIDTH-1:0] sel_word;
    logic             sel_mismatch;
    logic [CNT_W-1:0] cnt_q [4];

    assign head[0] = fifo4_out;
    assign head[1] = fifo5_out;
    assign head[2] = fifo6_out;
    assign head[3] = fifo7_out;

    assign avail = {~fifo7_empty, ~fifo6_empty, ~fifo5_empty, ~fifo4_empty};

    // Search upward from rr, wrapping 3->0; first non-empty FIFO wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr;
        scan_idx  = rr;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr + 2'(k);
            if (!grant_vld && avail[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign can_load     = ~valid_out | out_ready;
    assign do_pop       = reset & can_load & grant_vld;
    assign sel_word     = head[grant_idx];
    assign sel_mismatch = (sel_word[WIDTH-1 -: 2] != grant_idx);

    assign pop4 = do_pop && (grant_idx == 2'd0);
    assign pop5 = do_pop && (grant_idx == 2'd1);
    assign pop6 = do_pop && (grant_idx == 2'd2);
    assign pop7 = do_pop && (grant_idx == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            src_out   <= 2'd0;
            tag_err   <= 1'b0;
            err_count <= '0;
            rr        <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (do_pop) begin
            data_out         <= sel_word;
            src_out          <= grant_idx;
            valid_out        <= 1'b1;
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
            rr               <= grant_idx + 2'd1;
            tag_err          <= sel_mismatch;
            if (sel_mismatch && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end else begin
            // Stalled or idle: only a consumed word clears valid; data/src hold.
            tag_err <= 1'b0;
            if (out_ready) begin
                valid_out <= 1'b0;
            end
        end
    end

    assign cnt4 = cnt_q[0];
    assign cnt5 = cnt_q[1];
    assign cnt6 = cnt_q[2];
    assign cnt7 = cnt_q[3];

endmodule

// File: tb/tb_egress_drain_arbiter.sv
// Bench for egress_drain_arbiter: queue-backed FIFO models plus a behavioural
// reference of the arbitration rules, directed scenarios and a random phase.
module tb_egress_drain_arbiter;

    localparam int WIDTH = 10;
    localparam int CNT_W = 8;

    logic             clk   = 1'b1;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] fout [4];
    logic [3:0]       femp;
    logic [3:0]       fe;
    logic             pop4, pop5, pop6, pop7;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [1:0]       src_out;
    logic             tag_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] cnt4, cnt5, cnt6, cnt7;

    logic [WIDTH-1:0] q [4][$];
    int               pop_log [$];
    logic [WIDTH-1:0] delivered [$];

    int               n_checks = 0;
    int               n_fail   = 0;

    int               m_rr, m_valid, m_src, m_tag_err, m_err;
    logic [WIDTH-1:0] m_data;
    int               m_cnt [4];

    egress_drain_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .fifo4_out(fout[0]), .fifo5_out(fout[1]), .fifo6_out(fout[2]), .fifo7_out(fout[3]),
        .fifo4_empty(femp[0]), .fifo5_empty(femp[1]), .fifo6_empty(femp[2]), .fifo7_empty(femp[3]),
        .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
        .out_ready(out_ready), .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
        .tag_err(tag_err), .err_count(err_count),
        .cnt4(cnt4), .cnt5(cnt5), .cnt6(cnt6), .cnt7(cnt7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < 4; i++) begin
            femp[i] = (q[i].size() == 0) | fe[i];
            fout[i] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic push(input int f, input logic [WIDTH-1:0] w);
        q[f].push_back(w);
        drive_fifos();
    endtask

    function automatic logic [WIDTH-1:0] mk(input int tag);
        logic [1:0] t;
        t = 2'(tag);
        return {t, 8'($urandom)};
    endfunction

    task automatic reset_model();
        m_rr = 0; m_valid = 0; m_src = 0; m_tag_err = 0; m_err = 0; m_data = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic chk_outputs(input string pfx);
        chk({pfx, "_valid"}, 32'(valid_out), 32'(m_valid));
        chk({pfx, "_data"}, 32'(data_out), 32'(m_data));
        chk({pfx, "_src"}, 32'(src_out), 32'(m_src));
        chk({pfx, "_tag_err"}, 32'(tag_err), 32'(m_tag_err));
        chk({pfx, "_err_count"}, 32'(err_count), 32'(m_err));
        chk({pfx, "_cnt4"}, 32'(cnt4), 32'(m_cnt[0]));
        chk({pfx, "_cnt5"}, 32'(cnt5), 32'(m_cnt[1]));
        chk({pfx, "_cnt6"}, 32'(cnt6), 32'(m_cnt[2]));
        chk({pfx, "_cnt7"}, 32'(cnt7), 32'(m_cnt[3]));
    endtask

    // One clock: check at negedge, advance the reference after the rising edge.
    task automatic cycle();
        int               g;
        bit               gv;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        chk_outputs("cyc");
        if (valid_out && out_ready) delivered.push_back(data_out);
        gv = 0;
        g  = 0;
        if (m_valid == 0 || out_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (!gv && !femp[(m_rr + k) % 4]) begin
                    gv = 1;
                    g  = (m_rr + k) % 4;
                end
            end
        end
        chk("pop", 32'({pop7, pop6, pop5, pop4}), gv ? 32'(1 << g) : 32'd0);
        @(posedge clk);
        #1;
        if (gv) begin
            w = q[g].pop_front();
            pop_log.push_back(g);
            m_data    = w;
            m_src     = g;
            m_valid   = 1;
            m_cnt[g]  = (m_cnt[g] + 1) % 256;
            m_rr      = (g + 1) % 4;
            m_tag_err = (int'(w[WIDTH-1:WIDTH-2]) != g) ? 1 : 0;
            if (m_tag_err == 1 && m_err < 255) m_err++;
        end else begin
            m_tag_err = 0;
            if (out_ready) m_valid = 0;
        end
        drive_fifos();
    endtask

    initial begin
        logic [WIDTH-1:0] w7;
        logic [WIDTH-1:0] w;
        int               sum_in, sum_out;

        out_ready = 1'b1;
        fe        = 4'b0;
        reset_model();
        drive_fifos();

        // Reset with all FIFOs empty.
        #1 reset = 1'b0;
        #1;
        chk_outputs("rst");
        chk("rst_pop", 32'({pop7, pop6, pop5, pop4}), 32'd0);
        #14 reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle();

        // Two correctly tagged words per FIFO: strict rotation.
        pop_log.delete();
        for (int r = 0; r < 2; r++)
            for (int f = 0; f < 4; f++) push(f, mk(f));
        repeat (10) cycle();
        chk("rot_len", 32'(pop_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("rot_order", (i < pop_log.size()) ? 32'(pop_log[i]) : 32'd99, 32'(i % 4));
        chk("rot_cnt4", 32'(cnt4), 32'd2);
        chk("rot_cnt7", 32'(cnt7), 32'd2);
        chk("rot_err", 32'(err_count), 32'd0);
        chk("rot_idle", 32'(valid_out), 32'd0);

        // Only fifo6 non-empty.
        pop_log.delete();
        push(2, 10'h2A5);
        push(2, mk(2));
        push(2, mk(2));
        cycle();
        chk("f6_first_data", 32'(data_out), 32'h2A5);
        chk("f6_first_src", 32'(src_out), 32'd2);
        repeat (4) cycle();
        chk("f6_pops", 32'(pop_log.size()), 32'd3);

        // Backpressure with fifo4 and fifo7; rr should now point at fifo7.
        pop_log.delete();
        delivered.delete();
        sum_in = 0;
        for (int r = 0; r < 3; r++) begin
            w = mk(0); push(0, w); sum_in += int'(w);
            w = mk(3); push(3, w); sum_in += int'(w);
            if (r == 0) w7 = w;
        end
        cycle();
        chk("bp_first_src", (pop_log.size() > 0) ? 32'(pop_log[0]) : 32'd99, 32'd3);
        out_ready = 1'b0;
        repeat (5) begin
            cycle();
            chk("bp_stall_data", 32'(data_out), 32'(w7));
            chk("bp_stall_valid", 32'(valid_out), 32'd1);
        end
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_delivered", 32'(delivered.size()), 32'd6);
        sum_out = 0;
        foreach (delivered[i]) sum_out += int'(delivered[i]);
        chk("bp_sum", 32'(sum_out), 32'(sum_in));

        // Tag mismatch on fifo5.
        push(1, {2'b11, 8'h5A});
        cycle();
        chk("te_pulse", 32'(tag_err), 32'd1);
        chk("te_count", 32'(err_count), 32'd1);
        chk("te_data", 32'(data_out), 32'h35A);
        cycle();
        chk("te_clear", 32'(tag_err), 32'd0);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) push(1, mk(3));
        repeat (302) cycle();
        chk("sat_err", 32'(err_count), 32'd255);

        // Random phase: random tags, backpressure and late-rising empty flags.
        repeat (400) begin
            for (int f = 0; f < 4; f++)
                if (q[f].size() < 6 && $urandom_range(0, 2) == 0) push(f, mk(int'($urandom_range(0, 3))));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int f = 0; f < 4; f++) fe[f] = ($urandom_range(0, 7) == 0);
            drive_fifos();
            cycle();
        end
        fe        = 4'b0;
        out_ready = 1'b1;
        drive_fifos();
        repeat (30) cycle();

        // Reset with words in flight.
        for (int r = 0; r < 2; r++)
            for (int f = 0; f < 4; f++) push(f, mk(f));
        repeat (2) cycle();
        #2 reset = 1'b0;
        #1;
        reset_model();
        chk("rf_valid", 32'(valid_out), 32'd0);
        chk("rf_cnt4", 32'(cnt4), 32'd0);
        chk("rf_cnt5", 32'(cnt5), 32'd0);
        chk("rf_err", 32'(err_count), 32'd0);
        chk("rf_pop", 32'({pop7, pop6, pop5, pop4}), 32'd0);
        @(negedge clk);
        chk("rf_pop_hold", 32'({pop7, pop6, pop5, pop4}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        pop_log.delete();
        repeat (12) cycle();
        chk("rf_restart", (pop_log.size() > 0) ? 32'(pop_log[0]) : 32'd99, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
